galaga_dl_ctrl: RTL and testbench
=================================

GALAGA_DL_CTRL -- requirements
Module: galaga_dl_ctrl

Interface
REQ-001 Parameter: HOLD_CYCLES, default 1024, core reset extension after download end, in clk_sys cycles.
REQ-002 Parameter: ROM_INDEX, default 0, only ioctl_index value accepted as ROM image.
REQ-003 One clock; reset is synchronous and active-high: clk_sys  in  1  system clock (18 MHz domain).
REQ-004 reset  in  1  synchronous active-high reset.
REQ-005 ioctl_download  in  1  download window active.
REQ-006 ioctl_index  in  8  download target index.
REQ-007 ioctl_wr  in  1  one-cycle byte strobe.
REQ-008 ioctl_addr  in  25  byte address.
REQ-009 ioctl_dout  in  8  byte data.
REQ-010 dn_addr  out  16  region-relative write address.
REQ-011 dn_data  out  8  write data.
REQ-012 dn_wr  out  1  write strobe to game ROM port.
REQ-013 dn_region  out  3  target region code.
REQ-014 core_reset  out  1  reset to game core.
REQ-015 dl_busy  out  1  state is LOAD or HOLD.
REQ-016 dl_error  out  1  sticky error flag for current download.

Function
REQ-017 States: IDLE, LOAD, HOLD, READY; encoding from package.
REQ-018 IDLE/READY -> LOAD when ioctl_download rises and ioctl_index == ROM_INDEX; other index ignored, state unchanged.
REQ-019 LOAD -> HOLD on ioctl_download falling; hold counter loads HOLD_CYCLES-1.
REQ-020 HOLD decrements each cycle; HOLD -> READY the cycle after counter reaches 0.
REQ-021 ioctl_download rising during HOLD re-enters LOAD, counter cleared.
REQ-022 core_reset = 1 in IDLE, LOAD, HOLD, and whenever reset = 1; 0 only in READY.
REQ-023 In LOAD, each ioctl_wr with ioctl_addr inside a region produces dn_wr = 1 for exactly one cycle, one cycle later (latency 1), with dn_addr = ioctl_addr - region base, dn_data and dn_region registered from same cycle.
REQ-024 Region map (base, size): 0 CPU1 0x0000 0x4000; 1 CPU2 0x4000 0x1000; 2 CPU3 0x5000 0x1000; 3 GFX_CHR 0x6000 0x1000; 4 GFX_SPR 0x7000 0x2000; 5 PROM 0x9000 0x0400; total 0x9400.
REQ-025 ioctl_wr with ioctl_addr >= 0x9400 (any of bits 24:16 set included): no dn_wr, dl_error set.
REQ-026 ioctl_wr outside LOAD: ignored, no dn_wr, no error.
REQ-027 dl_error cleared on entry to LOAD; sticky until next LOAD entry or reset.
REQ-028 Back-to-back ioctl_wr on consecutive cycles produce consecutive dn_wr pulses, none dropped.
REQ-029 ioctl_download falling in same cycle as last ioctl_wr: that byte still written.
REQ-030 dn_addr, dn_data, dn_region hold last values when dn_wr = 0.

Reset
REQ-031 On reset: state IDLE, dn_wr 0, dn_addr 0, dn_data 0, dn_region 0, dl_error 0, hold counter 0, core_reset 1, dl_busy 0.
REQ-032 Reset during LOAD aborts; pending registered write not issued; IDLE until next download rising edge.

Configuration
REQ-033 Macro GALAGA_DL_CHECKSUM_EN defined: extra output dl_sum (8 bits), additive modulo-256 sum of every byte written via dn_wr, cleared on LOAD entry, frozen outside LOAD; checksum reset value 0.
REQ-034 Macro undefined: no dl_sum port, no checksum logic.

Structure
REQ-035 Package galaga_dl_pkg: state enum, region code constants, region base/size table, total size constant 0x9400.
REQ-036 Sub-module galaga_dl_region: combinational address -> {hit, region code, offset} decoder; controller registers its outputs.

Verification
REQ-037 Download index 0, bytes at 0x0000, 0x4000, 0x93FF -> dn_wr one cycle later, (region, addr) = (0,0x0000), (1,0x0000), (5,0x03FF).
REQ-038 Write at 0x9400 during LOAD -> no dn_wr, dl_error = 1; next download clears it.
REQ-039 Download end with HOLD_CYCLES=16 -> core_reset stays 1 for 16 cycles after falling edge, then 0, state READY.
REQ-040 Download with index 1 -> no dn_wr, state and core_reset unchanged.
REQ-041 Reset asserted mid-LOAD with write pending -> no dn_wr, all outputs at reset values next cycle.
REQ-042 With GALAGA_DL_CHECKSUM_EN, bytes 0xFF, 0x02 -> dl_sum = 0x01.

Source files
------------

// File: rtl/galaga_dl_pkg.sv
// Shared types and ROM layout for the Galaga download controller.
// Region table lists each game ROM region's base and size in the download image.
package galaga_dl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_READY = 2'd3
    } dl_state_t;

    localparam logic [2:0] RGN_CPU1    = 3'd0;
    localparam logic [2:0] RGN_CPU2    = 3'd1;
    localparam logic [2:0] RGN_CPU3    = 3'd2;
    localparam logic [2:0] RGN_GFX_CHR = 3'd3;
    localparam logic [2:0] RGN_GFX_SPR = 3'd4;
    localparam logic [2:0] RGN_PROM    = 3'd5;

    localparam int          NUM_REGIONS = 6;
    localparam logic [15:0] TOTAL_SIZE  = 16'h9400;

    // Index 0 is the rightmost entry.
    localparam logic [NUM_REGIONS-1:0][15:0] RGN_BASE = {
        16'h9000, 16'h7000, 16'h6000, 16'h5000, 16'h4000, 16'h0000
    };
    localparam logic [NUM_REGIONS-1:0][15:0] RGN_SIZE = {
        16'h0400, 16'h2000, 16'h1000, 16'h1000, 16'h1000, 16'h4000
    };

    function automatic logic in_region(input logic [15:0] addr, input int idx);
        logic [15:0] off;
        off = addr - RGN_BASE[idx];
        return (addr >= RGN_BASE[idx]) && (off < RGN_SIZE[idx]);
    endfunction

endpackage

// File: rtl/galaga_dl_ctrl_if.sv
// Download bus: loader-side ioctl byte stream in, ROM write port out.
// master = loader/ROM side, slave = the download controller.
interface galaga_dl_ctrl_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wr;
    logic [2:0]  dn_region;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_wr, dn_region
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_wr, dn_region
    );
endinterface

// File: rtl/galaga_dl_region.sv
// Combinational download-address decoder: {hit, region code, region offset}.
module galaga_dl_region
    import galaga_dl_pkg::*;
(
    input  logic [24:0] i_addr,
    output logic        o_hit,
    output logic [2:0]  o_region,
    output logic [15:0] o_offset
);

    always_comb begin
        o_hit    = 1'b0;
        o_region = 3'd0;
        o_offset = 16'd0;
        if (i_addr[24:16] == 9'd0 && i_addr[15:0] < TOTAL_SIZE) begin
            for (int i = 0; i < NUM_REGIONS; i++) begin
                if (in_region(i_addr[15:0], i)) begin
                    o_hit    = 1'b1;
                    o_region = 3'(i);
                    o_offset = i_addr[15:0] - RGN_BASE[i];
                end
            end
        end
    end

endmodule

// File: rtl/galaga_dl_ctrl.sv
// ROM download controller: routes ioctl bytes to game ROM regions and holds the core in reset.
// Optional GALAGA_DL_CHECKSUM_EN adds dl_sum, a mod-256 sum of bytes written in the current download.
module galaga_dl_ctrl
    import galaga_dl_pkg::*;
#(
    parameter int         HOLD_CYCLES = 1024,
    parameter logic [7:0] ROM_INDEX   = 8'd0
) (
    input  logic             clk_sys,
    input  logic             reset,
    galaga_dl_ctrl_if.slave  bus,
    output logic             core_reset,
    output logic             dl_busy,
`ifdef GALAGA_DL_CHECKSUM_EN
    output logic [7:0]       dl_sum,
`endif
    output logic             dl_error
);

    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    dl_state_t   r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic        r_dl_prev;
    logic        r_dn_wr;
    logic [15:0] r_dn_addr;
    logic [7:0]  r_dn_data;
    logic [2:0]  r_dn_region;
    logic        r_error;

    logic        w_rise, w_fall, w_idx_ok, w_load_entry;
    logic        w_cap, w_hit;
    logic [2:0]  w_region;
    logic [15:0] w_offset;

    galaga_dl_region u_region (
        .i_addr   (bus.ioctl_addr),
        .o_hit    (w_hit),
        .o_region (w_region),
        .o_offset (w_offset)
    );

    assign w_rise   = bus.ioctl_download & ~r_dl_prev;
    assign w_fall   = ~bus.ioctl_download & r_dl_prev;
    assign w_idx_ok = (bus.ioctl_index == ROM_INDEX);
    // A byte strobed in the same cycle the download window closes is still in LOAD here.
    assign w_cap    = (r_state == ST_LOAD) && bus.ioctl_wr;

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_load_entry = 1'b0;
        case (r_state)
            ST_IDLE, ST_READY: begin
                if (w_rise && w_idx_ok) begin
                    w_state_nxt  = ST_LOAD;
                    w_load_entry = 1'b1;
                end
            end
            ST_LOAD: begin
                if (w_fall) begin
                    w_state_nxt = ST_HOLD;
                    w_cnt_nxt   = CW'(HOLD_CYCLES - 1);
                end
            end
            ST_HOLD: begin
                if (w_rise && w_idx_ok) begin
                    w_state_nxt  = ST_LOAD;
                    w_cnt_nxt    = '0;
                    w_load_entry = 1'b1;
                end else if (r_cnt == '0) begin
                    w_state_nxt = ST_READY;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        // Tracked through reset so a window still open at reset release is not seen as a new start.
        r_dl_prev <= bus.ioctl_download;
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_dn_wr     <= 1'b0;
            r_dn_addr   <= 16'd0;
            r_dn_data   <= 8'd0;
            r_dn_region <= 3'd0;
            r_error     <= 1'b0;
        end else begin
            r_dn_wr <= w_cap && w_hit;
            if (w_cap && w_hit) begin
                r_dn_addr   <= w_offset;
                r_dn_data   <= bus.ioctl_dout;
                r_dn_region <= w_region;
            end
            if (w_load_entry)
                r_error <= 1'b0;
            else if (w_cap && !w_hit)
                r_error <= 1'b1;
        end
    end

`ifdef GALAGA_DL_CHECKSUM_EN
    logic [7:0] r_sum;

    always_ff @(posedge clk_sys) begin
        if (reset)
            r_sum <= 8'd0;
        else if (w_load_entry)
            r_sum <= 8'd0;
        else if (w_cap && w_hit)
            r_sum <= r_sum + bus.ioctl_dout;
    end

    assign dl_sum = r_sum;
`endif

    assign bus.dn_wr     = r_dn_wr;
    assign bus.dn_addr   = r_dn_addr;
    assign bus.dn_data   = r_dn_data;
    assign bus.dn_region = r_dn_region;

    assign core_reset = reset || (r_state != ST_READY);
    assign dl_busy    = (r_state == ST_LOAD) || (r_state == ST_HOLD);
    assign dl_error   = r_error;

endmodule

// File: tb/tb_galaga_dl_ctrl.sv
// Scoreboard bench for galaga_dl_ctrl (HOLD_CYCLES=16); checksum scenario runs with GALAGA_DL_CHECKSUM_EN.
module tb_galaga_dl_ctrl;

    typedef struct packed {
        logic [2:0]  rg;
        logic [15:0] a;
        logic [7:0]  d;
    } wr_t;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic core_reset, dl_busy, dl_error;
`ifdef GALAGA_DL_CHECKSUM_EN
    logic [7:0] dl_sum;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    wr_t exp_q[$];
    wr_t obs_q[$];

    galaga_dl_ctrl_if bus ();

    galaga_dl_ctrl #(.HOLD_CYCLES(16), .ROM_INDEX(8'd0)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .bus        (bus.slave),
        .core_reset (core_reset),
        .dl_busy    (dl_busy),
`ifdef GALAGA_DL_CHECKSUM_EN
        .dl_sum     (dl_sum),
`endif
        .dl_error   (dl_error)
    );

    always #5 clk_sys = ~clk_sys;

    // Records every cycle the ROM write strobe is high.
    always @(negedge clk_sys)
        if (bus.dn_wr === 1'b1)
            obs_q.push_back('{rg: bus.dn_region, a: bus.dn_addr, d: bus.dn_data});

    function automatic bit model(input logic [24:0] a, input logic [7:0] d, output wr_t e);
        logic [15:0] lo;
        lo = a[15:0];
        e  = '0;
        if (a[24:16] != 9'd0 || lo >= 16'h9400) return 1'b0;
        if      (lo < 16'h4000) e = '{rg: 3'd0, a: lo,            d: d};
        else if (lo < 16'h5000) e = '{rg: 3'd1, a: lo - 16'h4000, d: d};
        else if (lo < 16'h6000) e = '{rg: 3'd2, a: lo - 16'h5000, d: d};
        else if (lo < 16'h7000) e = '{rg: 3'd3, a: lo - 16'h6000, d: d};
        else if (lo < 16'h9000) e = '{rg: 3'd4, a: lo - 16'h7000, d: d};
        else                    e = '{rg: 3'd5, a: lo - 16'h9000, d: d};
        return 1'b1;
    endfunction

    task automatic tick();
        @(negedge clk_sys);
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        tick();
    endtask

    task automatic finish_dl();
        bus.ioctl_download = 1'b0;
        repeat (18) tick();
    endtask

    task automatic drive_wr(input logic [24:0] a, input logic [7:0] d, input bit in_load);
        wr_t e;
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = a;
        bus.ioctl_dout = d;
        if (in_load && model(a, d, e)) exp_q.push_back(e);
        tick();
        bus.ioctl_wr = 1'b0;
    endtask

    task automatic test_reset();
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_addr     = '0;
        bus.ioctl_dout     = '0;
        reset = 1'b1;
        repeat (2) tick();
        n_checks++;
        if ({core_reset, dl_busy, dl_error, bus.dn_wr} !== 4'b1000)
            begin n_fail++; $display("FAIL reset_flags got %b want 1000", {core_reset, dl_busy, dl_error, bus.dn_wr}); end
        n_checks++;
        if ({bus.dn_region, bus.dn_addr, bus.dn_data} !== 27'd0)
            begin n_fail++; $display("FAIL reset_dn got %h want 0", {bus.dn_region, bus.dn_addr, bus.dn_data}); end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({core_reset, dl_busy} !== 2'b10)
            begin n_fail++; $display("FAIL reset_idle got %b want 10", {core_reset, dl_busy}); end
    endtask

    task automatic test_regions();
        logic [24:0] addrs [8] = '{25'h0000, 25'h4000, 25'h93FF, 25'h5000, 25'h6FFF, 25'h7000, 25'h8FFF, 25'h9000};
        wr_t e, o;
        start_dl(8'd0);
        n_checks++;
        if ({core_reset, dl_busy, dl_error} !== 3'b110)
            begin n_fail++; $display("FAIL load_entry got %b want 110", {core_reset, dl_busy, dl_error}); end
        for (int i = 0; i < 8; i++) begin
            drive_wr(addrs[i], 8'hA0 + 8'(i), 1'b1);
            tick();
        end
        repeat (2) tick();
        n_checks++;
        if (obs_q.size() !== exp_q.size())
            begin n_fail++; $display("FAIL regions_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL regions_wr got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        finish_dl();
        n_checks++;
        if ({core_reset, dl_busy} !== 2'b00)
            begin n_fail++; $display("FAIL regions_ready got %b want 00", {core_reset, dl_busy}); end
    endtask

    task automatic test_oob();
        wr_t e, o;
        start_dl(8'd0);
        drive_wr(25'h9400, 8'h12, 1'b1);
        n_checks++;
        if (dl_error !== 1'b1) begin n_fail++; $display("FAIL oob_error got %b want 1", dl_error); end
        drive_wr(25'h10000, 8'h34, 1'b1);
        drive_wr(25'h0005, 8'h77, 1'b1);
        repeat (2) tick();
        n_checks++;
        if (obs_q.size() !== exp_q.size() || exp_q.size() !== 1)
            begin n_fail++; $display("FAIL oob_count got %0d want 1", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL oob_wr got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        finish_dl();
        n_checks++;
        if ({core_reset, dl_busy, dl_error} !== 3'b001)
            begin n_fail++; $display("FAIL oob_sticky got %b want 001", {core_reset, dl_busy, dl_error}); end
        start_dl(8'd0);
        n_checks++;
        if ({dl_busy, dl_error} !== 2'b10)
            begin n_fail++; $display("FAIL oob_clear got %b want 10", {dl_busy, dl_error}); end
        finish_dl();
    endtask

    task automatic test_hold();
        int bad;
        start_dl(8'd0);
        bus.ioctl_download = 1'b0;
        bad = 0;
        for (int i = 0; i < 16; i++) begin
            tick();
            if ({core_reset, dl_busy} !== 2'b11) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL hold_window got %0d bad cycles want 0", bad); end
        tick();
        n_checks++;
        if ({core_reset, dl_busy} !== 2'b00)
            begin n_fail++; $display("FAIL hold_release got %b want 00", {core_reset, dl_busy}); end
        // Restart during HOLD must reload the full hold time.
        start_dl(8'd0);
        bus.ioctl_download = 1'b0;
        repeat (5) tick();
        bus.ioctl_download = 1'b1;
        tick();
        bus.ioctl_download = 1'b0;
        repeat (16) tick();
        n_checks++;
        if ({core_reset, dl_busy} !== 2'b11)
            begin n_fail++; $display("FAIL hold_restart got %b want 11", {core_reset, dl_busy}); end
        tick();
        n_checks++;
        if ({core_reset, dl_busy} !== 2'b00)
            begin n_fail++; $display("FAIL hold_restart_end got %b want 00", {core_reset, dl_busy}); end
    endtask

    task automatic test_bad_index();
        obs_q.delete();
        start_dl(8'd1);
        drive_wr(25'h0000, 8'h11, 1'b0);
        repeat (2) tick();
        n_checks++;
        if ({core_reset, dl_busy, dl_error} !== 3'b000 || obs_q.size() !== 0)
            begin n_fail++; $display("FAIL bad_index got %b wr %0d want 000 wr 0", {core_reset, dl_busy, dl_error}, obs_q.size()); end
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        tick();
    endtask

    task automatic test_outside_load();
        obs_q.delete();
        drive_wr(25'h0100, 8'h22, 1'b0);
        repeat (2) tick();
        n_checks++;
        if (obs_q.size() !== 0 || dl_error !== 1'b0)
            begin n_fail++; $display("FAIL outside_load got wr %0d err %b want 0 0", obs_q.size(), dl_error); end
    endtask

    task automatic test_back_to_back();
        logic [24:0] addrs [5] = '{25'h3FFE, 25'h3FFF, 25'h4FFF, 25'h5000, 25'h9000};
        wr_t e, o;
        start_dl(8'd0);
        for (int i = 0; i < 5; i++) begin
            bus.ioctl_wr   = 1'b1;
            bus.ioctl_addr = addrs[i];
            bus.ioctl_dout = 8'hC1 + 8'(i);
            if (model(addrs[i], 8'hC1 + 8'(i), e)) exp_q.push_back(e);
            if (i == 4) bus.ioctl_download = 1'b0;
            tick();
        end
        bus.ioctl_wr = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (obs_q.size() !== exp_q.size() || exp_q.size() !== 5)
            begin n_fail++; $display("FAIL b2b_count got %0d want 5", obs_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_wr got %h want %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        repeat (16) tick();
        n_checks++;
        if ({core_reset, dl_busy, bus.dn_wr, bus.dn_region, bus.dn_addr, bus.dn_data} !== {3'b000, 3'd5, 16'h0000, 8'hC5})
            begin n_fail++; $display("FAIL b2b_hold got %h want %h",
                {core_reset, dl_busy, bus.dn_wr, bus.dn_region, bus.dn_addr, bus.dn_data}, {3'b000, 3'd5, 16'h0000, 8'hC5}); end
    endtask

    task automatic test_reset_mid_load();
        obs_q.delete();
        start_dl(8'd0);
        bus.ioctl_wr   = 1'b1;
        bus.ioctl_addr = 25'h0010;
        bus.ioctl_dout = 8'h99;
        reset = 1'b1;
        tick();
        bus.ioctl_wr = 1'b0;
        n_checks++;
        if ({core_reset, dl_busy, dl_error, bus.dn_wr, bus.dn_region, bus.dn_addr, bus.dn_data} !== {4'b1000, 27'd0})
            begin n_fail++; $display("FAIL midload_reset got %h want %h",
                {core_reset, dl_busy, dl_error, bus.dn_wr, bus.dn_region, bus.dn_addr, bus.dn_data}, {4'b1000, 27'd0}); end
        reset = 1'b0;
        repeat (2) tick();
        n_checks++;
        if ({core_reset, dl_busy} !== 2'b10 || obs_q.size() !== 0)
            begin n_fail++; $display("FAIL midload_idle got %b wr %0d want 10 wr 0", {core_reset, dl_busy}, obs_q.size()); end
        bus.ioctl_download = 1'b0;
        tick();
    endtask

`ifdef GALAGA_DL_CHECKSUM_EN
    task automatic test_checksum();
        start_dl(8'd0);
        n_checks++;
        if (dl_sum !== 8'h00) begin n_fail++; $display("FAIL sum_clear got %h want 00", dl_sum); end
        drive_wr(25'h0000, 8'hFF, 1'b1);
        drive_wr(25'h0001, 8'h02, 1'b1);
        drive_wr(25'h9400, 8'h40, 1'b1);
        finish_dl();
        drive_wr(25'h0002, 8'h10, 1'b0);
        tick();
        n_checks++;
        if (dl_sum !== 8'h01) begin n_fail++; $display("FAIL sum_value got %h want 01", dl_sum); end
        exp_q.delete(); obs_q.delete();
    endtask
`endif

    initial begin
        test_reset();
        test_regions();
        test_oob();
        test_hold();
        test_bad_index();
        test_outside_load();
        test_back_to_back();
        test_reset_mid_load();
`ifdef GALAGA_DL_CHECKSUM_EN
        test_checksum();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
